// File: rtl/fp_add_stream_if.sv
// Operand-in / result-out stream bundle for the FP add issue/collect stage.
// master drives operands and takes results; slave is the stage itself.
interface fp_add_stream_if #(
   parameter int unsigned WIDTH = 32
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/fp_add_stream.sv
// Issue/collect wrapper around a pipelined FP32 adder: credit-based admission
// guarantees every in-flight result has a free result-FIFO slot.
module fp_add_stream #(
   parameter int unsigned LATENCY    = 7,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned WIDTH      = 32
) (
   input  logic              clk,
   input  logic              areset,
   fp_add_stream_if.slave    stream,
   output logic [WIDTH-1:0]  add_a,
   output logic [WIDTH-1:0]  add_b,
   input  logic [WIDTH-1:0]  add_q,
   output logic              busy
);

   localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SW  = CW + 1;
   localparam int unsigned VW  = LATENCY + 2;

   logic [VW-1:0]    vsr;
   logic [CW-1:0]    inflight;
   logic [CW-1:0]    count;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [SW-1:0]    credits_used;
   logic             accept;
   logic             push;
   logic             pop;

   // Admission and status are pure functions of registers (plus reset).
   always_comb begin
      credits_used     = SW'(inflight) + SW'(count);
      stream.in_ready  = (credits_used < SW'(FIFO_DEPTH)) & areset;
      stream.out_valid = (count != '0);
      stream.out_data  = stream.out_valid ? mem[rd_ptr] : '0;
      busy             = (inflight != '0) | (count != '0);
      accept           = stream.in_valid & stream.in_ready;
      push             = vsr[VW-1];
      pop              = stream.out_valid & stream.out_ready;
   end

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         add_a    <= '0;
         add_b    <= '0;
         vsr      <= '0;
         inflight <= '0;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         if (accept) begin
            add_a <= stream.in_a;
            add_b <= stream.in_b;
         end
         vsr      <= {vsr[VW-2:0], accept};
         inflight <= inflight + CW'(accept) - CW'(push);
         count    <= count + CW'(push) - CW'(pop);
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
   end

   // Storage needs no reset: occupancy gates what is visible.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= add_q;
   end

endmodule

// File: tb/tb_fp_add_stream.sv
// Directed bench for fp_add_stream with a behavioural pipelined FP32 adder
// and an in-order scoreboard of expected sums.
module tb_fp_add_stream;
   localparam int unsigned LATENCY    = 7;
   localparam int unsigned FIFO_DEPTH = 16;
   localparam int unsigned WIDTH      = 32;

   logic             clk = 1'b0;
   logic             areset;
   logic [WIDTH-1:0] add_a, add_b, add_q;
   logic             busy;
   logic [WIDTH-1:0] pipe [0:LATENCY];

   fp_add_stream_if #(.WIDTH(WIDTH)) bus ();

   fp_add_stream #(.LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH), .WIDTH(WIDTH)) dut (
      .clk    (clk),
      .areset (areset),
      .stream (bus),
      .add_a  (add_a),
      .add_b  (add_b),
      .add_q  (add_q),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   function automatic real f2r(input logic [31:0] f);
      logic [63:0] d;
      if (f[30:23] == 8'd0) return 0.0;
      d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      d = $realtobits(r);
      if (d[62:0] == 63'd0) return 32'h0;
      return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
   endfunction

   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      return r2f(f2r(a) + f2r(b));
   endfunction

   function automatic logic [31:0] i2f(input int i);
      return r2f(real'(i));
   endfunction

   // Adder model: operands sampled at edge E give q stable after edge E+LATENCY.
   always @(posedge clk) begin
      pipe[0] <= fadd(add_a, add_b);
      for (int k = 1; k <= LATENCY; k++) pipe[k] <= pipe[k-1];
   end
   assign add_q = pipe[LATENCY];

   int pass_cnt = 0;
   int fail_cnt = 0;
   int total    = 0;
   int npop     = 0;
   logic [31:0] expq [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
      end
   endtask

   // One clock: score a pop, record an accept, then settle 1ns past the edge.
   task automatic step();
      logic acc, pp;
      logic [31:0] e;
      acc = bus.in_valid & bus.in_ready;
      pp  = bus.out_valid & bus.out_ready;
      if (pp) begin
         if (expq.size() == 0) chk("pop_unexpected", {31'd0, bus.out_valid}, 32'd0);
         else begin
            e = expq.pop_front();
            chk("pop_data", bus.out_data, e);
            npop++;
         end
      end
      if (acc) expq.push_back(fadd(bus.in_a, bus.in_b));
      @(posedge clk);
      #1;
   endtask

   initial begin
      int waited, accepts, cnt, sent, max_occ, pop0, idx;
      logic acc;

      areset        = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_a      = 32'h3f800000;
      bus.in_b      = 32'h3f800000;
      bus.out_ready = 1'b0;

      // Reset held with in_valid high
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      end
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_add_a", add_a, 32'h0);
      chk("rst_out_data", bus.out_data, 32'h0);
      bus.in_valid = 1'b0;
      areset = 1'b1;
      #1;
      chk("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
      step();

      // Single op, observe latency and output hold
      bus.in_valid = 1'b1;
      bus.in_a     = 32'h00000000;
      bus.in_b     = 32'h3f800000;
      step();
      bus.in_valid = 1'b0;
      chk("single_busy", {31'd0, busy}, 32'd1);
      for (int k = 1; k <= 9; k++) begin
         step();
         if (k == 8) chk("single_early", {31'd0, bus.out_valid}, 32'd0);
      end
      chk("single_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("single_data", bus.out_data, 32'h3f800000);
      step();
      step();
      chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("hold_data", bus.out_data, 32'h3f800000);
      chk("hold_busy", {31'd0, busy}, 32'd1);
      bus.out_ready = 1'b1;
      step();
      chk("single_drained", {31'd0, bus.out_valid}, 32'd0);
      chk("single_idle", {31'd0, busy}, 32'd0);

      // Back-to-back ordering
      bus.in_valid = 1'b1;
      bus.in_a = 32'h3f800000; bus.in_b = 32'h40000000;
      step();
      bus.in_a = 32'h3fc00000; bus.in_b = 32'h40200000;
      step();
      bus.in_valid = 1'b0;
      waited = 0;
      while (!bus.out_valid && waited < 30) begin step(); waited++; end
      chk("b2b_latency", 32'(waited), 32'd8);
      chk("b2b_first", bus.out_data, 32'h40400000);
      step();
      chk("b2b_second_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("b2b_second", bus.out_data, 32'h40800000);
      step();
      chk("b2b_empty", {31'd0, bus.out_valid}, 32'd0);

      // Full backpressure
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      idx = 1;
      bus.in_a = i2f(idx); bus.in_b = i2f(100);
      accepts = 0;
      for (int c = 0; c < 30; c++) begin
         acc = bus.in_valid & bus.in_ready;
         step();
         if (acc) begin
            accepts++; idx++;
            bus.in_a = i2f(idx);
         end
      end
      chk("bp_accepts", 32'(accepts), 32'd16);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      pop0 = npop;
      step();
      chk("bp_ready_after_pop", {31'd0, bus.in_ready}, 32'd1);
      for (int c = 0; c < 40 && expq.size() != 0; c++) step();
      chk("bp_pops", 32'(npop - pop0), 32'd16);
      chk("bp_empty", {31'd0, bus.out_valid}, 32'd0);

      // Reset with 2 results queued and 4 in flight
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_a = i2f(5); bus.in_b = i2f(6);
      step(); step();
      bus.in_valid = 1'b0;
      waited = 0;
      while (!bus.out_valid && waited < 30) begin step(); waited++; end
      step();
      bus.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) step();
      bus.in_valid = 1'b0;
      areset = 1'b0;
      #1;
      chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      expq.delete();
      step();
      areset = 1'b1;
      bus.out_ready = 1'b1;
      cnt = 0;
      for (int i = 0; i < 2 * LATENCY + 2; i++) begin
         if (bus.out_valid || busy) cnt++;
         step();
      end
      chk("midrst_stale", 32'(cnt), 32'd0);

      // Random streaming
      sent = 0; max_occ = 0; pop0 = npop;
      bus.in_a = i2f(int'($urandom_range(0, 1000)));
      bus.in_b = i2f(int'($urandom_range(0, 1000)));
      for (int c = 0; c < 3000 && !(sent == 64 && expq.size() == 0); c++) begin
         bus.in_valid  = (sent < 64) && ($urandom_range(0, 1) == 1);
         bus.out_ready = ($urandom_range(0, 1) == 1);
         acc = bus.in_valid & bus.in_ready;
         step();
         if (acc) begin
            sent++;
            bus.in_a = i2f(int'($urandom_range(0, 1000)));
            bus.in_b = i2f(int'($urandom_range(0, 1000)));
         end
         if (expq.size() > max_occ) max_occ = expq.size();
      end
      bus.in_valid = 1'b0;
      chk("stream_sent", 32'(sent), 32'd64);
      chk("stream_pops", 32'(npop - pop0), 32'd64);
      chk("stream_occ_le_depth", {31'd0, max_occ <= FIFO_DEPTH}, 32'd1);
      chk("stream_idle", {31'd0, busy}, 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/fp_add_stream.md
# fp_add_stream

Streaming issue/collect stage wrapped around the pipelined FP32 adder (`FP_ADD`). It accepts operand pairs over a valid/ready handshake and drives them into the adder's `a`/`b` inputs. It tracks in-flight operations with a valid shift register and captures each `q` into a result FIFO, which is drained over a second valid/ready handshake. Credit-based admission guarantees a result is never dropped, whatever the backpressure.

## Interface
- `LATENCY`, 7: adder register stages. `q` for operands sampled at edge E is stable during the cycle after edge E+LATENCY. Must be ≥1.
- `FIFO_DEPTH`, 16: result FIFO entries. Must be a power of two, ≥2. Full throughput needs ≥ LATENCY+3.
- `WIDTH`, 32: operand/result width (IEEE-754 single).

- `clk`  in  1  single clock, rising edge
- `areset`  in  1  asynchronous, active-low reset (asserted at 0)
- `in_valid`  in  1  operand pair offered
- `in_ready`  out  1  stage can accept a pair
- `in_a`, `in_b`  in  WIDTH  operands
- `add_a`, `add_b`  out  WIDTH  registered operands to `FP_ADD.a`/`.b`
- `add_q`  in  WIDTH  `FP_ADD.q`
- `out_valid`  out  1  FIFO head valid
- `out_ready`  in  1  consumer takes head
- `out_data`  out  WIDTH  FIFO head (first-word fall-through)
- `busy`  out  1  any op in flight or FIFO non-empty

## Operation
- **Accept:** accept = in_valid & in_ready. On accept, `add_a`/`add_b` load `in_a`/`in_b`. Otherwise they hold their last value. Values held while not accepting are never captured.
- **Valid shift register:** `vsr[LATENCY+1:0]`.
  - vsr[0] <= accept; vsr[k] <= vsr[k-1].
  - While vsr[LATENCY+1] is 1, the next edge pushes `add_q` into the FIFO.
- **Credit counters:** `inflight` counts operations accepted but not yet pushed; `count` is the FIFO occupancy.
  - `inflight` increments on accept and decrements on push. Both in the same edge: no change.
  - `count` increments on push and decrements on pop (out_valid & out_ready). Both in the same edge: no change.
- **Admission:**
  - in_ready = (inflight + count < FIFO_DEPTH) & areset.
  - in_ready is derived from registers only. There is no combinational path from `out_ready` or `in_valid`.
  - A pop frees its credit from the following cycle.
- **FIFO:**
  - Read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
  - A push never coincides with full; admission makes that state unreachable.
  - Push and pop in the same edge are both performed; occupancy is unchanged.
- **Status outputs:** out_valid = (count != 0). busy = (inflight != 0) | (count != 0).
- **Ordering:** results leave in acceptance order.

## Timing
- **Reset values:**
  - While `areset`=0: in_ready=0, out_valid=0, busy=0, add_a=add_b=0, out_data=0.
  - vsr, inflight, count and both pointers are 0.
- **Reset mid-operation:** all in-flight and FIFO'd results are discarded. Adder outputs emerging after reset release are ignored because vsr is clear.
- **After reset release:** in_ready=1 in the first cycle.
- **Latency:** accept at edge N gives the following sequence.
  - The adder samples the operands at edge N+1.
  - The FIFO push happens at edge N+LATENCY+2.
  - out_valid=1 in the cycle after that edge, provided the FIFO was empty: LATENCY+2 cycles from accept.
- **Throughput:** one pair per cycle sustained while out_ready=1 and FIFO_DEPTH ≥ LATENCY+3.
- **Backpressure:** with out_ready=0, in_ready drops after exactly FIFO_DEPTH accepts. It rises one cycle after the first pop.
- **Output hold:** `out_data` and `out_valid` stay stable while out_valid=1 and out_ready=0.

## Test plan
- **Reset:** hold areset=0 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, busy=0, no accept. After release, in_ready=1 on the first cycle.
- **Single op:** in_a=0x00000000, in_b=0x3f800000, one accept at edge N -> out_valid rises after edge N+9 (LATENCY=7), out_data=0x3f800000. busy=1 from edge N until the pop.
- **Back-to-back ordering:** accept (0x3f800000, 0x40000000) then (0x3fc00000, 0x40200000) on consecutive edges, out_ready=1 -> outputs 0x40400000 then 0x40800000 on consecutive cycles, in order.
- **Full backpressure:** out_ready=0, in_valid=1 continuous -> exactly 16 accepts, then in_ready=0. Release out_ready -> 16 results in order, and in_ready returns one cycle after the first pop.
- **Reset mid-flight:** 4 ops in flight plus 2 in the FIFO, pulse areset low for one cycle -> out_valid=0 and busy=0 immediately. No stale result appears in the following 2·LATENCY cycles.
- **Streaming:** 64 random pairs, random in_valid/out_ready at 50% -> all 64 results match the reference model in order. inflight+count never exceeds 16.
